ip_tx_arbiter: RTL

Two-input, packet-locked, round-robin arbiter that shares the single IP-layer transmit stream between two packet sources, port 0 (ICMP echo generator) and port 1 (UDP transmit path). It sits between the protocol generators and the IP header-insertion stage. It passes data, keep, last and the 56-bit user sideband of the granted source through one registered AXI-Stream slice. Per-port enables and per-port packet counters give management software control and visibility.

---
 rtl/ip_tx_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ip_tx_arbiter.sv
// Two-port, packet-locked, round-robin arbiter for the IP transmit stream.
// One registered output slice; per-port enables and forwarded-packet counters.
module ip_tx_arbiter #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned USER_W = 56,
    parameter int unsigned KEEP_W = DATA_W / 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,

    input  logic [DATA_W-1:0] s0_axis_ip_data,
    input  logic [USER_W-1:0] s0_axis_ip_user,
    input  logic [KEEP_W-1:0] s0_axis_ip_keep,
    input  logic              s0_axis_ip_last,
    input  logic              s0_axis_ip_valid,
    output logic              s0_axis_ip_ready,

    input  logic [DATA_W-1:0] s1_axis_ip_data,
    input  logic [USER_W-1:0] s1_axis_ip_user,
    input  logic [KEEP_W-1:0] s1_axis_ip_keep,
    input  logic              s1_axis_ip_last,
    input  logic              s1_axis_ip_valid,
    output logic              s1_axis_ip_ready,

    output logic [DATA_W-1:0] m_axis_ip_data,
    output logic [USER_W-1:0] m_axis_ip_user,
    output logic [KEEP_W-1:0] m_axis_ip_keep,
    output logic              m_axis_ip_last,
    output logic              m_axis_ip_valid,
    input  logic              m_axis_ip_ready,

    input  logic [1:0]        i_port_en,
    output logic [1:0]        o_grant,
    output logic [15:0]       o_pkt_cnt0,
    output logic [15:0]       o_pkt_cnt1
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              state_q;
    logic [1:0]          grant_q;
    logic [1:0]          grant_d;
    logic                last_q;

    logic                m_valid_q;
    logic                m_last_q;
    logic [DATA_W-1:0]   m_data_q;
    logic [USER_W-1:0]   m_user_q;
    logic [KEEP_W-1:0]   m_keep_q;

    logic [CNT_W-1:0]    pkt_cnt0_q;
    logic [CNT_W-1:0]    pkt_cnt0_d;
    logic [CNT_W-1:0]    pkt_cnt1_q;
    logic [CNT_W-1:0]    pkt_cnt1_d;

    logic [1:0]          req_c;
    logic                out_free_c;
    logic                s0_fire_c;
    logic                s1_fire_c;
    logic                fire_c;
    logic [DATA_W-1:0]   sel_data_c;
    logic [USER_W-1:0]   sel_user_c;
    logic [KEEP_W-1:0]   sel_keep_c;
    logic                sel_last_c;

    // Enables only gate new grants; an owned packet always runs to its last beat.
    assign req_c      = {s1_axis_ip_valid & i_port_en[1], s0_axis_ip_valid & i_port_en[0]};
    assign out_free_c = !m_valid_q || m_axis_ip_ready;

    assign s0_axis_ip_ready = (state_q == ST_BUSY) && grant_q[0] && out_free_c;
    assign s1_axis_ip_ready = (state_q == ST_BUSY) && grant_q[1] && out_free_c;

    assign s0_fire_c = s0_axis_ip_valid && s0_axis_ip_ready;
    assign s1_fire_c = s1_axis_ip_valid && s1_axis_ip_ready;
    assign fire_c    = s0_fire_c || s1_fire_c;

    // Beat mux follows the registered owner.
    always_comb begin
        sel_data_c = s0_axis_ip_data;
        sel_user_c = s0_axis_ip_user;
        sel_keep_c = s0_axis_ip_keep;
        sel_last_c = s0_axis_ip_last;
        if (grant_q[1]) begin
            sel_data_c = s1_axis_ip_data;
            sel_user_c = s1_axis_ip_user;
            sel_keep_c = s1_axis_ip_keep;
            sel_last_c = s1_axis_ip_last;
        end
    end

    // Round-robin pick: on a tie the port other than the previous owner wins.
    always_comb begin
        grant_d = req_c;
        if (req_c == 2'b11) begin
            grant_d = last_q ? 2'b01 : 2'b10;
        end
    end

    assign pkt_cnt0_d = pkt_cnt0_q + CNT_W'(1);
    assign pkt_cnt1_d = pkt_cnt1_q + CNT_W'(1);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= 2'b00;
            last_q     <= 1'b1;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            m_data_q   <= '0;
            m_user_q   <= '0;
            m_keep_q   <= '0;
            pkt_cnt0_q <= '0;
            pkt_cnt1_q <= '0;
        end else begin
            if (fire_c) begin
                m_valid_q <= 1'b1;
                m_data_q  <= sel_data_c;
                m_user_q  <= sel_user_c;
                m_keep_q  <= sel_keep_c;
                m_last_q  <= sel_last_c;
            end else if (m_axis_ip_ready) begin
                m_valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (req_c != 2'b00) begin
                        state_q <= ST_BUSY;
                        grant_q <= grant_d;
                    end
                end
                ST_BUSY: begin
                    if (fire_c && sel_last_c) begin
                        state_q <= ST_IDLE;
                        grant_q <= 2'b00;
                        last_q  <= grant_q[1];
                        if (grant_q[0]) begin
                            pkt_cnt0_q <= pkt_cnt0_d;
                        end else begin
                            pkt_cnt1_q <= pkt_cnt1_d;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    assign m_axis_ip_data  = m_data_q;
    assign m_axis_ip_user  = m_user_q;
    assign m_axis_ip_keep  = m_keep_q;
    assign m_axis_ip_last  = m_last_q;
    assign m_axis_ip_valid = m_valid_q;
    assign o_grant         = grant_q;
    assign o_pkt_cnt0      = pkt_cnt0_q;
    assign o_pkt_cnt1      = pkt_cnt1_q;

endmodule
